// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop input sync, false-start rejection, parity/framing/overrun
// flags, valid/ready output. Define UART_RX_MAJORITY_EN for 3-sample majority voting at sample points.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 520,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_rxd,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] out_rxd,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int IW   = $clog2(DATA_BITS);

  localparam logic [CW-1:0] C_HALF   = CW'(HALF);
  localparam logic [CW-1:0] C_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic                  r_stop_idx;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_perr;
  logic                  r_ferr;
  logic [DATA_BITS-1:0]  r_out;
  logic                  r_valid;
  logic                  r_perr_out;
  logic                  r_ferr_out;
  logic                  r_overrun;
  logic                  r_sync1;
  logic                  r_sync2;

  logic w_rxd_s;
  logic w_sample;
  logic w_tick;
  logic w_last_stop;
  logic w_par_bad;
  logic w_can_load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= in_rxd;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxd_s = r_sync2;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_hist;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], w_rxd_s};
    end
  end

  // Vote over the current and two previous synchronised values; a lone glitch loses.
  assign w_sample = (w_rxd_s & r_hist[0]) | (w_rxd_s & r_hist[1]) | (r_hist[0] & r_hist[1]);
`else
  assign w_sample = w_rxd_s;
`endif

  assign w_tick      = (r_cnt == C_LAST);
  assign w_last_stop = (STOP_BITS == 1) || r_stop_idx;
  assign w_par_bad   = (PARITY_MODE != 0) && (((^r_shift) ^ w_sample) != (PARITY_MODE == 2));
  // A finished frame may load when the holding slot is empty or being drained this cycle.
  assign w_can_load  = !r_valid || rx_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_out      <= '0;
      r_valid    <= 1'b0;
      r_perr_out <= 1'b0;
      r_ferr_out <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (!w_rxd_s) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end

        S_START: begin
          if (r_cnt == C_HALF) begin
            r_cnt <= '0;
            if (w_sample) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DATA;
              r_idx   <= '0;
              r_perr  <= 1'b0;
              r_ferr  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (w_tick) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= w_sample;
            if (r_idx == IDX_LAST) begin
              r_stop_idx <= 1'b0;
              r_state    <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_PARITY: begin
          if (w_tick) begin
            r_cnt      <= '0;
            r_perr     <= w_par_bad;
            r_stop_idx <= 1'b0;
            r_state    <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (w_tick) begin
            r_cnt <= '0;
            if (w_last_stop) begin
              if (w_can_load) begin
                r_out      <= r_shift;
                r_perr_out <= r_perr;
                r_ferr_out <= r_ferr | ~w_sample;
                r_valid    <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
              // A low final stop bit means the line may be held low; wait it out in BREAK.
              r_state <= w_sample ? S_IDLE : S_BREAK;
            end else begin
              r_stop_idx <= 1'b1;
              if (!w_sample) begin
                r_ferr <= 1'b1;
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_BREAK: begin
          if (w_rxd_s) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign out_rxd    = r_out;
  assign rx_valid   = r_valid;
  assign parity_err = r_perr_out;
  assign frame_err  = r_ferr_out;
  assign overrun    = r_overrun;
  assign rx_busy    = (r_state != S_IDLE);

endmodule
